// File: rtl/accel_mm_pkg.sv
// Shared definitions for the accelerator word-block register protocol.
// Holds the initiator state encoding, the register addresses the peripheral
// decodes, the data word type and the default job geometry.
package accel_mm_pkg;

  localparam int unsigned DataWidth   = 16;
  localparam int unsigned DefNumWords = 25;

  typedef logic [DataWidth-1:0] word_t;

  localparam word_t      DefOffset = 16'd5;
  localparam logic [2:0] WrAddr    = 3'h3;
  localparam logic [2:0] RdAddr    = 3'h4;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWrTerm,
    StWaitDone,
    StRead,
    StRdTerm,
    StWaitClr,
    StFinish
  } state_e;

endpackage

// File: rtl/accel_mm_initiator_if.sv
// Signal bundle between the job initiator and its environment: host job
// control (start/busy/finish/pass/error_count/timeout), the valid/ready word
// source, the peripheral register port and the result stream.
// master: the initiator side. slave: host, source and peripheral side.
interface accel_mm_initiator_if #(
  parameter int unsigned CNT_BITS = 5
) ();
  import accel_mm_pkg::*;

  logic                start;
  logic                busy;
  logic                src_valid;
  word_t               src_data;
  logic                src_ready;
  logic                av_chipselect;
  logic [2:0]          av_address;
  logic                av_write;
  logic                av_read;
  word_t               av_writedata;
  word_t               av_readdata;
  logic                dut_done;
  logic                res_valid;
  word_t               res_data;
  logic                finish;
  logic                pass;
  logic [CNT_BITS-1:0] error_count;
  logic                timeout;

  modport master (
    input  start, src_valid, src_data, av_readdata, dut_done,
    output busy, src_ready, av_chipselect, av_address, av_write, av_read,
           av_writedata, res_valid, res_data, finish, pass, error_count, timeout
  );

  modport slave (
    output start, src_valid, src_data, av_readdata, dut_done,
    input  busy, src_ready, av_chipselect, av_address, av_write, av_read,
           av_writedata, res_valid, res_data, finish, pass, error_count, timeout
  );

endinterface

// File: rtl/accel_word_buf.sv
// Register file holding the words sent during a job so the returned words
// can be checked. One synchronous write port, one combinational read port.
// Contents are not reset.
//   clk_i           clock
//   we_i/waddr_i/wdata_i   write port
//   raddr_i/rdata_o        read port (out-of-range index reads 0)
module accel_word_buf
  import accel_mm_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DefNumWords,
  parameter int unsigned IDX_BITS  = 5
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] waddr_i,
  input  word_t               wdata_i,
  input  logic [IDX_BITS-1:0] raddr_i,
  output word_t               rdata_o
);

  word_t mem_q [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < IDX_BITS'(NUM_WORDS))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (raddr_i < IDX_BITS'(NUM_WORDS)) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/accel_mm_initiator.sv
// Bus-master end of the accelerator word-block protocol. Per job: take
// NUM_WORDS words from the source and write them to WR_ADDR, write a zero
// terminator, wait for done, read NUM_WORDS results from RD_ADDR, issue a
// terminator read, wait for done to clear, then report pass/fail.
//   clk, reset (async, active low)
//   bus: accel_mm_initiator_if master modport (host, source, bus, results)
module accel_mm_initiator
  import accel_mm_pkg::*;
#(
  parameter int unsigned NUM_WORDS    = DefNumWords,
  parameter int unsigned CNT_BITS     = 5,
  parameter logic [2:0]  WR_ADDR      = WrAddr,
  parameter logic [2:0]  RD_ADDR      = RdAddr,
  parameter word_t       OFFSET       = DefOffset,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  accel_mm_initiator_if.master bus
);

  localparam int unsigned WaitBits = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [CNT_BITS-1:0] LastIdx  = CNT_BITS'(NUM_WORDS - 1);
  localparam logic [WaitBits-1:0] LastWait = WaitBits'(DONE_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [WaitBits-1:0] wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [2:0]          addr_q, addr_d;
  word_t               wdata_q, wdata_d;
  // Read pipeline: a data read is on the bus (pend), then its data returns (cap).
  logic                pend_q, pend_d, cap_q, cap_d;
  logic [CNT_BITS-1:0] pend_idx_q, pend_idx_d, cap_idx_q, cap_idx_d;
  logic                res_valid_q, res_valid_d;
  word_t               res_data_q, res_data_d;
  logic                finish_q, finish_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [CNT_BITS-1:0] err_q, err_d;

  logic  buf_we;
  word_t buf_rdata;
  word_t exp_word;

  accel_word_buf #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_BITS  (CNT_BITS)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (bus.src_data),
    .raddr_i (cap_idx_q),
    .rdata_o (buf_rdata)
  );

  assign exp_word = buf_rdata + OFFSET;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    cs_d        = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    pend_d      = 1'b0;
    pend_idx_d  = pend_idx_q;
    cap_d       = pend_q;
    cap_idx_d   = pend_idx_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    finish_d    = 1'b0;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    buf_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_d     = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          wr_idx_d  = '0;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (bus.src_valid) begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = WR_ADDR;
          wdata_d = bus.src_data;
          buf_we  = 1'b1;
          if (wr_idx_q == LastIdx) begin
            state_d = StWrTerm;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StWrTerm: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = WR_ADDR;
        wait_d  = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.dut_done) begin
          rd_idx_d = '0;
          state_d  = StRead;
        end else if (wait_q == LastWait) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRead: begin
        cs_d       = 1'b1;
        rd_d       = 1'b1;
        addr_d     = RD_ADDR;
        pend_d     = 1'b1;
        pend_idx_d = rd_idx_q;
        if (rd_idx_q == LastIdx) begin
          state_d = StRdTerm;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      StRdTerm: begin
        // Terminator read: pend stays low so its data is never captured.
        cs_d    = 1'b1;
        rd_d    = 1'b1;
        addr_d  = RD_ADDR;
        wait_d  = '0;
        state_d = StWaitClr;
      end
      StWaitClr: begin
        if (!bus.dut_done) begin
          state_d = StFinish;
        end else if (wait_q == LastWait) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StFinish: begin
        finish_d = 1'b1;
        pass_d   = (err_q == '0) && !timeout_q;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Read data is valid the cycle after its strobe; check it against the sent word.
    if (cap_q) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.av_readdata;
      if ((bus.av_readdata != exp_word) && (err_q != '1)) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      cap_q       <= 1'b0;
      cap_idx_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      finish_q    <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      cap_q       <= cap_d;
      cap_idx_q   <= cap_idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      finish_q    <= finish_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.src_ready     = (state_q == StWrite);
  assign bus.av_chipselect = cs_q;
  assign bus.av_address    = addr_q;
  assign bus.av_write      = wr_q;
  assign bus.av_read       = rd_q;
  assign bus.av_writedata  = wdata_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
  assign bus.finish        = finish_q;
  assign bus.pass          = pass_q;
  assign bus.error_count   = err_q;
  assign bus.timeout       = timeout_q;

endmodule
